// File: rtl/rx_sysdata_pkg.sv
// rtl/rx_sysdata_pkg.sv - test pattern constants, state encoding and lookup for the rx data checker
package rx_sysdata_pkg;

  localparam logic [7:0] PAT0 = 8'h89;
  localparam logic [7:0] PAT1 = 8'h55;
  localparam logic [7:0] PAT2 = 8'hCC;
  localparam logic [7:0] PAT3 = 8'hAA;

  localparam logic [2:0] BAUD_SEL_DEFAULT = 3'b111;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    LOCKING = 2'd1,
    LOCKED  = 2'd2
  } chk_state_t;

  function automatic logic [7:0] pat_byte(input logic [1:0] i);
    case (i)
      2'd0:    pat_byte = PAT0;
      2'd1:    pat_byte = PAT1;
      2'd2:    pat_byte = PAT2;
      default: pat_byte = PAT3;
    endcase
  endfunction

endpackage

// File: rtl/sysdata_sat_counter.sv
// rtl/sysdata_sat_counter.sv - W-bit saturating up-counter with synchronous clear
module sysdata_sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/rx_system_data_checker.sv
// rtl/rx_system_data_checker.sv - checks received bytes against the cyclic test pattern; RX_CHECK_STATS_EN adds good_count
module rx_system_data_checker
  import rx_sysdata_pkg::*;
#(
  parameter logic [2:0] BAUD_SEL   = BAUD_SEL_DEFAULT,
  parameter int         LOCK_COUNT = 4,
  parameter int         ERR_CNT_W  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [7:0]           Rx_DATA,
  input  logic                 Rx_VALID,
  input  logic                 Rx_FERROR,
  input  logic                 Rx_PERROR,
  output logic                 Rx_EN,
  output logic [2:0]           Rx_baud_select,
  output logic                 locked,
  output logic                 match_pulse,
  output logic                 mismatch_pulse,
  output logic                 line_err_pulse,
  output logic [7:0]           expected_byte,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [15:0]          good_count
);

  chk_state_t state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [3:0] run_q, run_d;
  logic       match_d, mismatch_d, line_err_d;
  logic       byte_ok, is_good;
  logic       hunt_hit;
  logic [1:0] hunt_idx;

  assign Rx_baud_select = BAUD_SEL;

  always_comb begin
    byte_ok  = !Rx_FERROR && !Rx_PERROR;
    is_good  = Rx_VALID && byte_ok && (Rx_DATA == pat_byte(idx_q));
    hunt_hit = 1'b0;
    hunt_idx = 2'd0;
    // Pattern bytes are distinct, so at most one position can hit.
    for (int k = 0; k < 4; k++) begin
      if (Rx_DATA == pat_byte(2'(k))) begin
        hunt_hit = 1'b1;
        hunt_idx = 2'(k);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    run_d      = run_q;
    match_d    = 1'b0;
    mismatch_d = 1'b0;
    line_err_d = 1'b0;
    if (Rx_VALID) begin
      line_err_d = Rx_FERROR || Rx_PERROR;
      case (state_q)
        HUNT: begin
          if (byte_ok && hunt_hit) begin
            idx_d   = hunt_idx + 2'd1;
            run_d   = 4'd1;
            state_d = (LOCK_COUNT == 1) ? LOCKED : LOCKING;
          end
        end
        LOCKING: begin
          if (is_good) begin
            idx_d = idx_q + 2'd1;
            run_d = run_q + 4'd1;
            if (int'(run_q) + 1 == LOCK_COUNT) state_d = LOCKED;
          end else begin
            state_d = HUNT;
            idx_d   = 2'd0;
            run_d   = 4'd0;
          end
        end
        LOCKED: begin
          if (is_good) begin
            match_d = 1'b1;
            idx_d   = idx_q + 2'd1;
          end else begin
            mismatch_d = 1'b1;
            state_d    = HUNT;
            idx_d      = 2'd0;
            run_d      = 4'd0;
          end
        end
        default: begin
          state_d = HUNT;
          idx_d   = 2'd0;
          run_d   = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= HUNT;
      idx_q          <= 2'd0;
      run_q          <= 4'd0;
      locked         <= 1'b0;
      match_pulse    <= 1'b0;
      mismatch_pulse <= 1'b0;
      line_err_pulse <= 1'b0;
      expected_byte  <= 8'h00;
      Rx_EN          <= 1'b0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      run_q          <= run_d;
      locked         <= (state_d == LOCKED);
      match_pulse    <= match_d;
      mismatch_pulse <= mismatch_d;
      line_err_pulse <= line_err_d;
      expected_byte  <= (state_d == HUNT) ? 8'h00 : pat_byte(idx_d);
      Rx_EN          <= 1'b1;
    end
  end

  // Counters see the same incrementing event as the pulse registers, so both update on one edge.
  sysdata_sat_counter #(.W(ERR_CNT_W)) u_err_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (mismatch_d),
    .clr   (1'b0),
    .count (err_count)
  );

`ifdef RX_CHECK_STATS_EN
  sysdata_sat_counter #(.W(16)) u_good_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (match_d),
    .clr   (1'b0),
    .count (good_count)
  );
`else
  assign good_count = 16'h0000;
`endif

endmodule

// File: tb/tb_rx_system_data_checker.sv
// tb/tb_rx_system_data_checker.sv - directed self-checking bench for rx_system_data_checker
module tb_rx_system_data_checker;

`ifdef RX_CHECK_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_valid, rx_ferror, rx_perror;

  logic       en_a, lk_a, mp_a, mm_a, le_a;
  logic [2:0] bs_a;
  logic [7:0] eb_a, ec_a;
  logic [15:0] gc_a;

  logic       en_b, lk_b, mp_b, mm_b, le_b;
  logic [2:0] bs_b;
  logic [7:0] eb_b;
  logic [1:0] ec_b;
  logic [15:0] gc_b;

  logic       en_c, lk_c, mp_c, mm_c, le_c;
  logic [2:0] bs_c;
  logic [7:0] eb_c, ec_c;
  logic [15:0] gc_c;

  int n_total = 0;
  int n_bad   = 0;
  logic [7:0] pat [4] = '{8'h89, 8'h55, 8'hCC, 8'hAA};

  always #5 clk = ~clk;

  rx_system_data_checker dut (
    .clk(clk), .reset(reset), .Rx_DATA(rx_data), .Rx_VALID(rx_valid),
    .Rx_FERROR(rx_ferror), .Rx_PERROR(rx_perror), .Rx_EN(en_a),
    .Rx_baud_select(bs_a), .locked(lk_a), .match_pulse(mp_a),
    .mismatch_pulse(mm_a), .line_err_pulse(le_a), .expected_byte(eb_a),
    .err_count(ec_a), .good_count(gc_a)
  );

  rx_system_data_checker #(.ERR_CNT_W(2)) dut_w2 (
    .clk(clk), .reset(reset), .Rx_DATA(rx_data), .Rx_VALID(rx_valid),
    .Rx_FERROR(rx_ferror), .Rx_PERROR(rx_perror), .Rx_EN(en_b),
    .Rx_baud_select(bs_b), .locked(lk_b), .match_pulse(mp_b),
    .mismatch_pulse(mm_b), .line_err_pulse(le_b), .expected_byte(eb_b),
    .err_count(ec_b), .good_count(gc_b)
  );

  rx_system_data_checker #(.LOCK_COUNT(1)) dut_lc1 (
    .clk(clk), .reset(reset), .Rx_DATA(rx_data), .Rx_VALID(rx_valid),
    .Rx_FERROR(rx_ferror), .Rx_PERROR(rx_perror), .Rx_EN(en_c),
    .Rx_baud_select(bs_c), .locked(lk_c), .match_pulse(mp_c),
    .mismatch_pulse(mm_c), .line_err_pulse(le_c), .expected_byte(eb_c),
    .err_count(ec_c), .good_count(gc_c)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the following negedge with the byte's results registered.
  task automatic send(input logic [7:0] d, input logic fe, input logic pe);
    rx_data   = d;
    rx_valid  = 1'b1;
    rx_ferror = fe;
    rx_perror = pe;
    @(negedge clk);
    rx_valid  = 1'b0;
    rx_ferror = 1'b0;
    rx_perror = 1'b0;
  endtask

  task automatic send_cycle(input int start);
    for (int i = 0; i < 4; i++) send(pat[(start + i) % 4], 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1; rx_data = 8'h00; rx_valid = 1'b0; rx_ferror = 1'b0; rx_perror = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_locked", 32'(lk_a), 32'd0);
    check("rst_exp", 32'(eb_a), 32'h00);
    check("rst_err", 32'(ec_a), 32'd0);
    check("rst_rx_en", 32'(en_a), 32'd0);
    check("rst_good", 32'(gc_a), 32'd0);
    check("baud_sel", 32'(bs_a), 32'h7);
    reset = 1'b0;
    @(negedge clk);
    check("rx_en_up", 32'(en_a), 32'd1);

    send(8'h89, 1'b0, 1'b0);
    check("locking_exp", 32'(eb_a), 32'h55);
    check("locking_nolock", 32'(lk_a), 32'd0);
    check("lc1_lock_first", 32'(lk_c), 32'd1);
    send(8'h55, 1'b0, 1'b0);
    send(8'hCC, 1'b0, 1'b0);
    check("lock3_exp", 32'(eb_a), 32'hAA);
    check("lock3_nolock", 32'(lk_a), 32'd0);
    send(8'hAA, 1'b0, 1'b0);
    check("lock4_locked", 32'(lk_a), 32'd1);
    check("lock4_exp", 32'(eb_a), 32'h89);
    check("lock4_err", 32'(ec_a), 32'd0);
    check("lock4_nomatch", 32'(mp_a), 32'd0);

    send(8'h89, 1'b0, 1'b0);
    check("wrap_match", 32'(mp_a), 32'd1);
    check("wrap_exp", 32'(eb_a), 32'h55);
    send(8'h55, 1'b0, 1'b0);
    check("m2_exp", 32'(eb_a), 32'hCC);
    send(8'h13, 1'b0, 1'b0);
    check("bad_mismatch", 32'(mm_a), 32'd1);
    check("bad_err", 32'(ec_a), 32'd1);
    check("bad_unlock", 32'(lk_a), 32'd0);
    check("bad_exp", 32'(eb_a), 32'h00);
    check("bad_noline", 32'(le_a), 32'd0);
    @(negedge clk);
    check("mismatch_1cyc", 32'(mm_a), 32'd0);

    send_cycle(2);
    check("mid_locked", 32'(lk_a), 32'd1);
    check("mid_exp", 32'(eb_a), 32'hCC);
    send(8'hCC, 1'b0, 1'b0);
    check("mid_match", 32'(mp_a), 32'd1);
    check("mid_exp2", 32'(eb_a), 32'hAA);
    check("good_3", 32'(gc_a), STATS ? 32'd3 : 32'd0);

    send(8'hAA, 1'b0, 1'b1);
    check("perr_line", 32'(le_a), 32'd1);
    check("perr_mismatch", 32'(mm_a), 32'd1);
    check("perr_err", 32'(ec_a), 32'd2);
    check("perr_unlock", 32'(lk_a), 32'd0);

    for (int r = 0; r < 3; r++) begin
      send_cycle(0);
      send(8'h00, 1'b0, 1'b0);
    end
    check("err_5", 32'(ec_a), 32'd5);
    check("w2_sat", 32'(ec_b), 32'd3);

    send(8'h55, 1'b0, 1'b0);
    check("lc1_locked", 32'(lk_c), 32'd1);
    check("lc1_exp", 32'(eb_c), 32'hCC);
    check("lc4_not_locked", 32'(lk_a), 32'd0);
    send(8'h00, 1'b0, 1'b0);
    check("locking_bad_noerr", 32'(ec_a), 32'd5);
    check("locking_bad_exp", 32'(eb_a), 32'h00);

    send(8'h89, 1'b1, 1'b0);
    check("hunt_ferr_line", 32'(le_a), 32'd1);
    check("hunt_ferr_nomm", 32'(mm_a), 32'd0);
    check("hunt_ferr_exp", 32'(eb_a), 32'h00);

    send_cycle(0);
    send(8'h89, 1'b0, 1'b0);
    check("pre_rst_match", 32'(mp_a), 32'd1);
    #1 reset = 1'b1;
    #1;
    check("arst_locked", 32'(lk_a), 32'd0);
    check("arst_match", 32'(mp_a), 32'd0);
    check("arst_err", 32'(ec_a), 32'd0);
    check("arst_exp", 32'(eb_a), 32'h00);
    check("arst_rx_en", 32'(en_a), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    send_cycle(0);
    for (int i = 0; i < 10; i++) send(pat[i % 4], 1'b0, 1'b0);
    check("stats_locked", 32'(lk_a), 32'd1);
    check("stats_exp", 32'(eb_a), 32'hCC);
    check("stats_good", 32'(gc_a), STATS ? 32'd10 : 32'd0);
    check("stats_err", 32'(ec_a), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
